// File: rtl/skid_fifo.sv
// rtl/skid_fifo.sv - multi-entry elastic buffer with registered handshake, level and almost-full
// The head word always sits in the dn_bus register; storage holds every word, head included.
module skid_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AFULL      = DEPTH - 1,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] up_bus,
  input  logic                  up_val,
  output logic                  up_rdy,
  output logic [DATA_WIDTH-1:0] dn_bus,
  output logic                  dn_val,
  input  logic                  dn_rdy,
  output logic [LW-1:0]         level,
  output logic                  almost_full
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         rd_nxt;
  logic [LW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dn_bus_q, dn_bus_d;
  logic                  up_rdy_q, dn_val_q, afull_q;
  logic                  push, pop;

  assign push   = up_val & up_rdy_q;
  assign pop    = dn_val_q & dn_rdy;
  assign rd_nxt = rd_ptr_q + PW'(1);

  always_comb begin
    count_d  = count_q + LW'(push) - LW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
    dn_bus_d = dn_bus_q;
    if (count_q == '0) begin
      if (push) dn_bus_d = up_bus;
    end else if (pop && (count_d != '0)) begin
      // With a single stored word the successor is the one arriving this cycle.
      if (count_q == LW'(1)) dn_bus_d = up_bus;
      else                   dn_bus_d = mem_q[rd_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dn_bus_q <= '0;
      up_rdy_q <= 1'b0;
      dn_val_q <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dn_bus_q <= dn_bus_d;
      up_rdy_q <= (count_d != LW'(DEPTH));
      dn_val_q <= (count_d != '0);
      afull_q  <= (count_d >= LW'(AFULL));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= up_bus;
  end

  assign up_rdy      = up_rdy_q;
  assign dn_bus      = dn_bus_q;
  assign dn_val      = dn_val_q;
  assign level       = count_q;
  assign almost_full = afull_q;

endmodule

// File: tb/tb_skid_fifo.sv
// tb/tb_skid_fifo.sv - scoreboard bench for skid_fifo: directed scenarios plus random stress
module tb_skid_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] up_bus = '0;
  logic          up_val = 1'b0;
  logic          up_rdy;
  logic [DW-1:0] dn_bus;
  logic          dn_val;
  logic          dn_rdy = 1'b0;
  logic [LW-1:0] level;
  logic          almost_full;

  int total = 0;
  int bad   = 0;
  logic          chk_en = 1'b0;
  logic [DW-1:0] exp_q [$];

  skid_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .rst(rst),
    .up_bus(up_bus), .up_val(up_val), .up_rdy(up_rdy),
    .dn_bus(dn_bus), .dn_val(dn_val), .dn_rdy(dn_rdy),
    .level(level), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every accepted word is expected downstream in arrival order.
  always @(posedge clk) begin
    if (!rst && up_val && up_rdy) exp_q.push_back(up_bus);
  end

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_bus   = '0;
  logic [DW-1:0] popped;

  always @(negedge clk) begin
    if (rst || !chk_en) begin
      prev_stall = 1'b0;
    end else begin
      check("mon_level", 32'(level), 32'(exp_q.size()));
      check("mon_dn_val", 32'(dn_val), 32'(exp_q.size() != 0));
      check("mon_up_rdy", 32'(up_rdy), 32'(exp_q.size() != DEPTH));
      check("mon_almost_full", 32'(almost_full), 32'(exp_q.size() >= AFULL));
      if (dn_val && exp_q.size() != 0) check("mon_head", dn_bus, exp_q[0]);
      if (prev_stall) check("mon_stall_hold", dn_bus, prev_bus);
      if (dn_val && dn_rdy) begin
        if (exp_q.size() == 0) check("mon_pop_nonempty", 32'(0), 32'(1));
        else popped = exp_q.pop_front();
      end
      prev_stall = dn_val && !dn_rdy;
      prev_bus   = dn_bus;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic took;

  initial begin
    // Asynchronous reset, checked before any clock edge sees it.
    #2 rst = 1'b1;
    #1;
    check("rst_up_rdy", 32'(up_rdy), 32'(0));
    check("rst_dn_val", 32'(dn_val), 32'(0));
    check("rst_dn_bus", dn_bus, 32'(0));
    check("rst_level", 32'(level), 32'(0));
    check("rst_almost_full", 32'(almost_full), 32'(0));
    #9 rst = 1'b0;
    #1;
    check("rel_up_rdy_before_edge", 32'(up_rdy), 32'(0));
    tick();
    check("rel_up_rdy_after_edge", 32'(up_rdy), 32'(1));
    check("rel_level", 32'(level), 32'(0));
    chk_en = 1'b1;

    // Single word through an empty buffer.
    up_val = 1'b1; up_bus = 32'hA5A5_0001; dn_rdy = 1'b1;
    tick();
    up_val = 1'b0;
    check("single_dn_val", 32'(dn_val), 32'(1));
    check("single_dn_bus", dn_bus, 32'hA5A5_0001);
    check("single_level", 32'(level), 32'(1));
    tick();
    check("single_dn_val_drop", 32'(dn_val), 32'(0));
    check("single_level_zero", 32'(level), 32'(0));
    check("single_bus_retained", dn_bus, 32'hA5A5_0001);

    // Fill to full with downstream stalled.
    dn_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      up_val = 1'b1; up_bus = 32'(i);
      tick();
      check("fill_level", 32'(level), 32'(i));
      check("fill_almost_full", 32'(almost_full), 32'(i >= AFULL));
      check("fill_head_held", dn_bus, 32'(1));
    end
    check("full_up_rdy", 32'(up_rdy), 32'(0));
    up_val = 1'b1; up_bus = 32'd5;
    tick();
    check("full_hold_level", 32'(level), 32'(4));
    check("full_hold_head", dn_bus, 32'(1));

    // One pop at full: one-cycle bubble, then word 5 lands in the wrapped slot.
    dn_rdy = 1'b1;
    tick();
    dn_rdy = 1'b0;
    check("bubble_up_rdy", 32'(up_rdy), 32'(1));
    check("bubble_level", 32'(level), 32'(3));
    tick();
    up_val = 1'b0;
    check("refill_level", 32'(level), 32'(4));
    check("refill_up_rdy", 32'(up_rdy), 32'(0));
    dn_rdy = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("drain_order", dn_bus, 32'(i));
      tick();
    end
    check("drain_empty", 32'(dn_val), 32'(0));
    check("drain_level", 32'(level), 32'(0));

    // Streaming at one word per cycle.
    up_val = 1'b1;
    for (int i = 0; i < 100; i++) begin
      up_bus = 32'(100 + i);
      tick();
      check("stream_data", dn_bus, 32'(100 + i));
      check("stream_level", 32'(level), 32'(1));
    end
    up_val = 1'b0;
    tick();
    check("stream_end_level", 32'(level), 32'(0));

    // Random stress with a mid-run reset, upstream obeying hold-until-accepted.
    took = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) begin
        #2 rst = 1'b1;
        exp_q.delete();
        chk_en = 1'b0;
        #1;
        check("midrst_dn_val", 32'(dn_val), 32'(0));
        check("midrst_up_rdy", 32'(up_rdy), 32'(0));
        check("midrst_level", 32'(level), 32'(0));
        check("midrst_dn_bus", dn_bus, 32'(0));
        check("midrst_almost_full", 32'(almost_full), 32'(0));
        up_val = 1'b0;
        took = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        check("midrst_up_rdy_back", 32'(up_rdy), 32'(1));
        chk_en = 1'b1;
      end
      if (!up_val || took) begin
        up_val = ($urandom_range(0, 3) != 0);
        up_bus = $urandom;
      end
      if (((c / 500) % 2) == 0) dn_rdy = ($urandom_range(0, 3) == 0);
      else                      dn_rdy = ($urandom_range(0, 3) != 0);
      took = up_val && up_rdy;
      tick();
    end

    up_val = 1'b0;
    dn_rdy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    check("final_empty_level", 32'(level), 32'(0));
    check("final_queue_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skid_fifo.md
# skid_fifo

Parametrised elastic buffer for valid/ready streaming pipelines: a multi-entry successor to the single-entry skid register, with configurable depth, registered handshake outputs, an occupancy count and an almost-full flag. Sits between any two valid/ready pipeline stages to break the `dn_rdy` → `up_rdy` combinational path and absorb bursts of back-pressure. It is a drop-in replacement wherever `DEPTH` > 2 or occupancy visibility is needed.

## Interface
- `DATA_WIDTH`, 32, payload width in bits (≥1)
- `DEPTH`, 4, total capacity in words, power of two, ≥2; includes the word presented on `dn_bus`
- `AFULL`, `DEPTH-1`, almost-full threshold, 1..`DEPTH`
- `LW` (localparam), `$clog2(DEPTH)+1`, width of `level`

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, asynchronous and active-high
- `up_bus` in `DATA_WIDTH`: upstream payload
- `up_val` in 1: upstream valid
- `up_rdy` out 1: upstream ready, registered
- `dn_bus` out `DATA_WIDTH`: downstream payload, registered
- `dn_val` out 1: downstream valid, registered
- `dn_rdy` in 1: downstream ready
- `level` out `LW`: current occupancy 0..`DEPTH`, registered
- `almost_full` out 1: registered, high when `level` ≥ `AFULL`

## Operation
- `push = up_val & up_rdy`; `pop = dn_val & dn_rdy`; `count_next = count + push - pop`, computed at `LW` bits; never exceeds `DEPTH` and never underflows.
- FIFO order is strict: words leave in arrival order; no drop, no duplication.
- Storage is a circular buffer with read/write pointers of `$clog2(DEPTH)` bits. The pointers wrap naturally at `DEPTH`, which is guaranteed by the power-of-two rule.
- The head word is always held in the `dn_bus` register.
  - When empty and a push occurs, `dn_bus` ← `up_bus` (bypass).
  - On a pop with `count_next` > 0, `dn_bus` ← the next-oldest word. If that word is being pushed in the same cycle (`count` = 1 with push and pop), it is taken from `up_bus`.
- `dn_val` ← (`count_next` ≠ 0); `up_rdy` ← (`count_next` ≠ `DEPTH`); `level` ← `count_next`; `almost_full` ← (`count_next` ≥ `AFULL`).
- `dn_bus` must not change while `dn_val & ~dn_rdy`. It is also unchanged while empty (`dn_val`=0).
- Upstream protocol: `up_bus` is held stable while `up_val & ~up_rdy`, and `up_val` falls only after a transfer. The block does not check this.
- No state machine beyond the pointer/count datapath; effective states are EMPTY (count=0), PARTIAL, FULL (count=`DEPTH`).

## Timing
- Reset (async assert, takes effect immediately):
  - `up_rdy`=0, `dn_val`=0, `dn_bus`=0, `level`=0, `almost_full`=0, pointers=0.
  - Storage array not reset.
  - `up_rdy` rises at the first `clk` edge after `rst` deasserts.
- Reset mid-operation discards all contents. Outputs go to reset values within the same cycle, without waiting for a clock.
- Latency: a word pushed into an empty buffer appears on `dn_bus` with `dn_val`=1 one cycle later.
- Throughput: one word per cycle sustained in both directions while not FULL.
- Simultaneous push and pop: `count` unchanged; both pointers advance.
- FULL: `up_rdy`=0. A pop at FULL raises `up_rdy` on the next cycle, so upstream sees exactly one cycle with `up_rdy`=0 per pop-at-full (registered-ready bubble).
- EMPTY with push: `dn_val` is 1 next cycle; `level` is 1.
- Pop of last word with no push: `dn_val`=0 next cycle; `dn_bus` retains its last value.
- `almost_full` and `level` update on the same edge as `up_rdy` and `dn_val`; there is no additional lag.

## Test plan
- Reset then idle: `rst` pulse asynchronous to `clk` → all outputs 0 immediately; `up_rdy`=1 at first edge after release; `level`=0.
- Single word, `DEPTH`=4: push `32'hA5A5_0001` with `dn_rdy`=1 → `dn_val`=1 and `dn_bus`=`32'hA5A5_0001` the next cycle, `level`=1, then `dn_val`=0 and `level`=0 the following cycle.
- Fill to full, `DEPTH`=4, `AFULL`=3, `dn_rdy`=0: push 1,2,3,4 back-to-back → `almost_full`=1 after the third push; `up_rdy`=0 and `level`=4 after the fourth; `dn_bus` holds 1 stably.
- Drain with wrap-around: from the full state, pulse `dn_rdy` once while upstream holds word 5 valid → `up_rdy` returns 1 one cycle after the pop. Word 5 enters in the slot after the pointer wrap. Full drain yields 2,3,4,5 in order.
- Streaming: `up_val`=1 and `dn_rdy`=1 continuously for 100 incrementing words → one word per cycle, `level` constant at 1, output sequence identical to input.
- Random stress: random `up_val`/`dn_rdy` over 10k cycles, with a mid-run `rst` → scoreboard matches in order, `dn_bus` stable under stall, `level` tracks the push/pop delta, and no data survives the reset.
